sdram_cmd_responder: RTL and testbench
======================================

Name: sdram_cmd_responder

Overview:
- Synthesizable SDRAM device-side responder. It decodes the pin-level commands that the controller's command generator drives: clock enable, chip select, RAS/CAS/WE, bank, address, DQM and DQ.
- It tracks per-bank open-row state and timing, stores write data in an internal array, and returns read data after CAS latency.
- It flags protocol and timing violations.
- It sits on the SDRAM pin side of the controller in block-level benches and FPGA loopback builds.

Parameters:
- CL, 2, CAS latency: cycles from RD sample to read data valid (legal 1..3).
- T_RCD, 2, minimum cycles from ACT to RD/WR on the same bank.
- T_RP, 3, minimum cycles from PRE to ACT on the same bank.
- MEM_AW, 10, storage index width. Index = {bank[1:0], row[1:0], col[5:0]}, taken from the row latched at ACT and the column bits of Addr.

Ports:
- sclk  in  1  clock
- sresetn  in  1  asynchronous active-low reset
- iClkEn  in  1  clock enable; 0 means the cycle is ignored
- iCsn  in  1  chip select, active low
- iRasn  in  1  RAS, active low
- iCasn  in  1  CAS, active low
- iWen  in  1  WE, active low
- iBank  in  2  bank select
- iAddr  in  11  row (ACT) or column (RD/WR); bit 10 is the all-bank / auto-precharge flag
- iDqm  in  4  byte mask, 1 = masked
- iDq  in  32  write data, sampled with WR
- oDq  out  32  read data
- oDqOe  out  1  read data drive enable
- oErr  out  1  sticky protocol error
- oErrCode  out  3  code of the first error

Behaviour:
- Clock, reset and sampling:
  - One clock domain; reset is asynchronous and active-low.
  - A command is sampled when iClkEn=1 and iCsn=0; otherwise the cycle is treated as a NOP.
- Command decode on {iRasn,iCasn,iWen}:
  - 111 NOP
  - 011 ACT
  - 101 RD
  - 100 WR
  - 000 PRE (the encoding our generator drives)
  - 010 PRE
  - 001 and 110 are ignored.
  - For PRE, iAddr[10]=1 precharges all banks; iAddr[10]=0 precharges iBank only.
- Per-bank FSM states: IDLE, ACTIVATING, ACTIVE, PRECHARGING, each bank with a 3-bit down-timer.
  - IDLE --ACT--> ACTIVATING: row latched, timer=T_RCD-1. On reaching 0 → ACTIVE.
  - ACTIVATING/ACTIVE --PRE--> PRECHARGING: timer=T_RP-1. On reaching 0 → IDLE.
  - PRE to an IDLE bank: legal no-op.
  - RD/WR with iAddr[10]=1 (auto-precharge): the access completes, then the bank enters PRECHARGING next cycle.
- WR (burst length 1):
  - Byte b of iDq is written at the index when iDqm[b]=0.
  - The write is visible to a RD issued the following cycle.
- RD:
  - Read data is pushed into a CL-deep pipeline together with the iDqm captured at the RD.
  - At exit, oDqOe=1 and oDq holds the stored word, with masked bytes forced to 0x00.
  - Back-to-back RDs give back-to-back data.
  - When no data is exiting, oDqOe=0 and oDq=0.
- Errors. The offending command is discarded: no state change, no write, no read data.
  - 1 = RD/WR to a bank in IDLE or PRECHARGING.
  - 2 = ACT to a bank not in IDLE (covers ACT during PRECHARGING and ACT to an open bank).
  - 3 = RD/WR to an ACTIVATING bank (tRCD violation).
  - 4 = ACT while a PRE timer is running (tRP). This is reported as code 4 instead of 2 when the bank is PRECHARGING.
  - 5 = WR while any read data is in the pipeline (DQ bus conflict).
  - If two codes apply in the same cycle, the lowest code wins.
  - oErr/oErrCode latch the first error only and clear only on reset.
- Reset values:
  - oDq=0, oDqOe=0, oErr=0, oErrCode=0.
  - All banks IDLE, timers 0, read pipeline flushed.
  - Storage contents are not reset.
- Reset asserted mid-read: the pipeline is dropped and no stale data appears after release.

Test Plan:
- Write/read hit. ACT b1 row 0x005; wait 2 cycles; WR col 0x12 data 0xDEADBEEF dqm 0; RD col 0x12 → oDqOe=1 with oDq=0xDEADBEEF exactly 2 cycles after the RD sample; oErr=0.
- Byte masking. Memory holds 0xDEADBEEF; WR 0x11223344 with dqm=4'b0101 → a later RD returns 0x11AD33EF. RD with dqm=4'b1000 → 0x00AD33EF.
- tRCD violation. ACT b2 then RD b2 on the next cycle → oErr=1, oErrCode=3, oDqOe stays 0. A later legal RD still works and the code stays 3.
- Precharge and tRP. Open b0 and b3; PRE with iAddr=0x400 → both banks IDLE. ACT b0 one cycle later → code 4. After reset, ACT at cycle 3 after PRE → accepted.
- Closed-bank and conflict. RD to an IDLE bank → code 1. In a fresh run, RD then WR on the next cycle with CL=2 → code 5; the WR data is not stored.
- Reset mid-read and deselect. Assert sresetn=0 one cycle after a RD → no oDqOe after release. A WR with iCsn=1 or iClkEn=0 → memory unchanged.

Source files
------------

// File: rtl/sdram_cmd_responder.sv
// Device-side SDRAM responder: decodes pin-level commands, tracks per-bank row and
// timing state, stores write data and returns read data after the CAS latency.
module sdram_cmd_responder #(
    parameter int CL     = 2,
    parameter int T_RCD  = 2,
    parameter int T_RP   = 3,
    parameter int MEM_AW = 10
) (
    input  logic        sclk,
    input  logic        sresetn,
    input  logic        iClkEn,
    input  logic        iCsn,
    input  logic        iRasn,
    input  logic        iCasn,
    input  logic        iWen,
    input  logic [1:0]  iBank,
    input  logic [10:0] iAddr,
    input  logic [3:0]  iDqm,
    input  logic [31:0] iDq,
    output logic [31:0] oDq,
    output logic        oDqOe,
    output logic        oErr,
    output logic [2:0]  oErrCode
);

    typedef enum logic [1:0] {
        BANK_IDLE,
        BANK_ACTIVATING,
        BANK_ACTIVE,
        BANK_PRECHARGING
    } bankState_t;

    localparam logic [2:0] RCD_LOAD = 3'(T_RCD - 1);
    localparam logic [2:0] RP_LOAD  = 3'(T_RP - 1);

    logic [2:0] cmdBits;
    logic       cmdSel;
    logic       cmdAct;
    logic       cmdRd;
    logic       cmdWr;
    logic       cmdPre;

    assign cmdSel  = iClkEn & ~iCsn;
    assign cmdBits = {iRasn, iCasn, iWen};
    assign cmdAct  = cmdSel && (cmdBits == 3'b011);
    assign cmdRd   = cmdSel && (cmdBits == 3'b101);
    assign cmdWr   = cmdSel && (cmdBits == 3'b100);
    assign cmdPre  = cmdSel && ((cmdBits == 3'b000) || (cmdBits == 3'b010));

    // Column bits above 5 do not reach the storage index.
    logic unusedAddr;
    assign unusedAddr = ^iAddr[9:6];

    bankState_t bankState     [4];
    bankState_t bankStateNext [4];
    logic [2:0] bankTimer     [4];
    logic [2:0] bankTimerNext [4];
    logic [1:0] bankRow       [4];
    logic [1:0] bankRowNext   [4];

    bankState_t selState;
    logic [2:0] errCode;
    logic       cmdOk;
    logic       readBusy;

    assign selState = bankState[iBank];

    // Checks are ordered so the lowest applicable code wins; a PRECHARGING
    // target reports the tRP code rather than the generic "bank not idle" one.
    always_comb begin
        errCode = 3'd0;
        if (cmdRd || cmdWr) begin
            if ((selState == BANK_IDLE) || (selState == BANK_PRECHARGING)) begin
                errCode = 3'd1;
            end else if (selState == BANK_ACTIVATING) begin
                errCode = 3'd3;
            end else if (cmdWr && readBusy) begin
                errCode = 3'd5;
            end
        end else if (cmdAct) begin
            if (selState == BANK_PRECHARGING) begin
                errCode = 3'd4;
            end else if (selState != BANK_IDLE) begin
                errCode = 3'd2;
            end
        end
    end

    assign cmdOk = (errCode == 3'd0);

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            bankStateNext[b] = bankState[b];
            bankTimerNext[b] = bankTimer[b];
            bankRowNext[b]   = bankRow[b];

            case (bankState[b])
                BANK_ACTIVATING: begin
                    if (bankTimer[b] <= 3'd1) begin
                        bankStateNext[b] = BANK_ACTIVE;
                        bankTimerNext[b] = 3'd0;
                    end else begin
                        bankTimerNext[b] = bankTimer[b] - 3'd1;
                    end
                end
                BANK_PRECHARGING: begin
                    if (bankTimer[b] <= 3'd1) begin
                        bankStateNext[b] = BANK_IDLE;
                        bankTimerNext[b] = 3'd0;
                    end else begin
                        bankTimerNext[b] = bankTimer[b] - 3'd1;
                    end
                end
                default: ;
            endcase

            if ((iBank == 2'(b)) && cmdAct && cmdOk) begin
                bankRowNext[b] = iAddr[1:0];
                if (T_RCD <= 1) begin
                    bankStateNext[b] = BANK_ACTIVE;
                    bankTimerNext[b] = 3'd0;
                end else begin
                    bankStateNext[b] = BANK_ACTIVATING;
                    bankTimerNext[b] = RCD_LOAD;
                end
            end

            // Explicit precharge and auto-precharge after an accepted access.
            if ((cmdPre && (iAddr[10] || (iBank == 2'(b))) &&
                 ((bankState[b] == BANK_ACTIVATING) || (bankState[b] == BANK_ACTIVE))) ||
                ((iBank == 2'(b)) && (cmdRd || cmdWr) && cmdOk && iAddr[10])) begin
                if (T_RP <= 1) begin
                    bankStateNext[b] = BANK_IDLE;
                    bankTimerNext[b] = 3'd0;
                end else begin
                    bankStateNext[b] = BANK_PRECHARGING;
                    bankTimerNext[b] = RP_LOAD;
                end
            end
        end
    end

    always_ff @(posedge sclk or negedge sresetn) begin
        if (!sresetn) begin
            for (int b = 0; b < 4; b++) begin
                bankState[b] <= BANK_IDLE;
                bankTimer[b] <= 3'd0;
                bankRow[b]   <= 2'd0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                bankState[b] <= bankStateNext[b];
                bankTimer[b] <= bankTimerNext[b];
                bankRow[b]   <= bankRowNext[b];
            end
        end
    end

    logic [31:0]       mem [0:(1 << MEM_AW) - 1];
    logic [MEM_AW-1:0] memIdx;

    assign memIdx = MEM_AW'({iBank, bankRow[iBank], iAddr[5:0]});

    // Storage is deliberately left unreset so contents survive a reset pulse.
    always_ff @(posedge sclk) begin
        if (cmdWr && cmdOk) begin
            for (int k = 0; k < 4; k++) begin
                if (!iDqm[k]) begin
                    mem[memIdx][8*k +: 8] <= iDq[8*k +: 8];
                end
            end
        end
    end

    logic [CL-1:0] pipeValid;
    logic [31:0]   pipeData [CL];
    logic [3:0]    pipeDqm  [CL];
    logic [31:0]   exitData;

    always_comb begin
        exitData = '0;
        for (int k = 0; k < 4; k++) begin
            exitData[8*k +: 8] = pipeDqm[CL-1][k] ? 8'h00 : pipeData[CL-1][8*k +: 8];
        end
    end

    // The bus stays busy until the last read word has left the output register.
    assign readBusy = (|pipeValid) | oDqOe;

    always_ff @(posedge sclk or negedge sresetn) begin
        if (!sresetn) begin
            pipeValid <= '0;
            for (int i = 0; i < CL; i++) begin
                pipeData[i] <= '0;
                pipeDqm[i]  <= '0;
            end
            oDq   <= '0;
            oDqOe <= 1'b0;
        end else begin
            pipeValid[0] <= cmdRd && cmdOk;
            pipeData[0]  <= mem[memIdx];
            pipeDqm[0]   <= iDqm;
            for (int i = 1; i < CL; i++) begin
                pipeValid[i] <= pipeValid[i-1];
                pipeData[i]  <= pipeData[i-1];
                pipeDqm[i]   <= pipeDqm[i-1];
            end
            oDqOe <= pipeValid[CL-1];
            oDq   <= pipeValid[CL-1] ? exitData : '0;
        end
    end

    always_ff @(posedge sclk or negedge sresetn) begin
        if (!sresetn) begin
            oErr     <= 1'b0;
            oErrCode <= 3'd0;
        end else if (!oErr && !cmdOk) begin
            oErr     <= 1'b1;
            oErrCode <= errCode;
        end
    end

endmodule

// File: tb/tb_sdram_cmd_responder.sv
// Bench for sdram_cmd_responder: directed scenarios plus random traffic checked
// against a cycle-stamped behavioural model of banks, storage and read returns.
module tb_sdram_cmd_responder;

    localparam int CL    = 2;
    localparam int T_RCD = 2;
    localparam int T_RP  = 3;

    localparam logic [2:0] C_NOP  = 3'b111;
    localparam logic [2:0] C_ACT  = 3'b011;
    localparam logic [2:0] C_RD   = 3'b101;
    localparam logic [2:0] C_WR   = 3'b100;
    localparam logic [2:0] C_PRE  = 3'b000;
    localparam logic [2:0] C_PRE2 = 3'b010;

    localparam int ST_IDLE    = 0;
    localparam int ST_OPENING = 1;
    localparam int ST_OPEN    = 2;
    localparam int ST_CLOSING = 3;

    logic        sclk    = 1'b0;
    logic        sresetn = 1'b0;
    logic        iClkEn  = 1'b0;
    logic        iCsn    = 1'b1;
    logic        iRasn   = 1'b1;
    logic        iCasn   = 1'b1;
    logic        iWen    = 1'b1;
    logic [1:0]  iBank   = '0;
    logic [10:0] iAddr   = '0;
    logic [3:0]  iDqm    = '0;
    logic [31:0] iDq     = '0;
    logic [31:0] oDq;
    logic        oDqOe;
    logic        oErr;
    logic [2:0]  oErrCode;

    int checks = 0;
    int errors = 0;

    always #5 sclk = ~sclk;

    sdram_cmd_responder #(
        .CL(CL), .T_RCD(T_RCD), .T_RP(T_RP), .MEM_AW(10)
    ) dut (
        .sclk(sclk), .sresetn(sresetn), .iClkEn(iClkEn), .iCsn(iCsn),
        .iRasn(iRasn), .iCasn(iCasn), .iWen(iWen), .iBank(iBank),
        .iAddr(iAddr), .iDqm(iDqm), .iDq(iDq), .oDq(oDq), .oDqOe(oDqOe),
        .oErr(oErr), .oErrCode(oErrCode)
    );

    // Model: banks are described by the cycle of their last ACT / PRE.
    int          cyc = 0;
    bit          bankOpen [4];
    bit          preValid [4];
    int          actAt    [4];
    int          preAt    [4];
    int          openRow  [4];
    logic [7:0]  memModel [1024][4];
    bit          memKnown [1024][4];
    bit          schedValid [16];
    logic [31:0] schedData  [16];
    logic [31:0] schedCare  [16];
    int          lastRead;
    bit          expErr;
    logic [2:0]  expCode;
    bit          expOe;
    logic [31:0] expDq;
    logic [31:0] expCare;

    function automatic int bankStatus(input int b);
        if (bankOpen[b]) return ((cyc - actAt[b]) >= T_RCD) ? ST_OPEN : ST_OPENING;
        if (preValid[b] && ((cyc - preAt[b]) < T_RP)) return ST_CLOSING;
        return ST_IDLE;
    endfunction

    task automatic modelReset();
        for (int b = 0; b < 4; b++) begin
            bankOpen[b] = 1'b0;
            preValid[b] = 1'b0;
        end
        for (int s = 0; s < 16; s++) schedValid[s] = 1'b0;
        lastRead = -1000;
        expErr   = 1'b0;
        expCode  = 3'd0;
        expOe    = 1'b0;
        expDq    = '0;
        expCare  = '1;
    endtask

    task automatic closeBank(input int b);
        bankOpen[b] = 1'b0;
        preValid[b] = 1'b1;
        preAt[b]    = cyc;
    endtask

    task automatic modelStep(input bit cke, input bit csn, input logic [2:0] cmd,
                             input logic [1:0] bank, input logic [10:0] addr,
                             input logic [3:0] dqm, input logic [31:0] dq);
        bit sel   = cke && !csn;
        bit isAct = sel && (cmd == C_ACT);
        bit isRd  = sel && (cmd == C_RD);
        bit isWr  = sel && (cmd == C_WR);
        bit isPre = sel && ((cmd == C_PRE) || (cmd == C_PRE2));
        int b     = int'(bank);
        int st    = bankStatus(b);
        int code  = 0;
        int idx;
        int slot;
        // Candidates from highest to lowest so the smallest applicable one remains.
        if (isWr && ((cyc - lastRead) <= CL + 1)) code = 5;
        if (isAct && (st == ST_CLOSING)) code = 4;
        if ((isRd || isWr) && (st == ST_OPENING)) code = 3;
        if (isAct && ((st == ST_OPENING) || (st == ST_OPEN))) code = 2;
        if ((isRd || isWr) && ((st == ST_IDLE) || (st == ST_CLOSING))) code = 1;

        idx = b * 256 + openRow[b] * 64 + int'(addr[5:0]);
        if (code != 0) begin
            if (!expErr) begin
                expErr  = 1'b1;
                expCode = 3'(code);
            end
        end else if (isAct) begin
            bankOpen[b] = 1'b1;
            actAt[b]    = cyc;
            openRow[b]  = int'(addr[1:0]);
        end else if (isPre) begin
            for (int k = 0; k < 4; k++) begin
                if ((addr[10] || (k == b)) && bankOpen[k]) closeBank(k);
            end
        end else if (isRd) begin
            slot = (cyc + CL) % 16;
            schedValid[slot] = 1'b1;
            for (int k = 0; k < 4; k++) begin
                if (dqm[k]) begin
                    schedData[slot][8*k +: 8] = 8'h00;
                    schedCare[slot][8*k +: 8] = 8'hFF;
                end else begin
                    schedData[slot][8*k +: 8] = memModel[idx][k];
                    schedCare[slot][8*k +: 8] = memKnown[idx][k] ? 8'hFF : 8'h00;
                end
            end
            lastRead = cyc;
            if (addr[10]) closeBank(b);
        end else if (isWr) begin
            for (int k = 0; k < 4; k++) begin
                if (!dqm[k]) begin
                    memModel[idx][k] = dq[8*k +: 8];
                    memKnown[idx][k] = 1'b1;
                end
            end
            if (addr[10]) closeBank(b);
        end

        slot    = cyc % 16;
        expOe   = schedValid[slot];
        expDq   = expOe ? schedData[slot] : 32'h0;
        expCare = expOe ? schedCare[slot] : 32'hFFFF_FFFF;
        schedValid[slot] = 1'b0;
    endtask

    task automatic issue(input bit cke, input bit csn, input logic [2:0] cmd,
                         input logic [1:0] bank, input logic [10:0] addr,
                         input logic [3:0] dqm, input logic [31:0] dq);
        iClkEn = cke;
        iCsn   = csn;
        {iRasn, iCasn, iWen} = cmd;
        iBank  = bank;
        iAddr  = addr;
        iDqm   = dqm;
        iDq    = dq;
        modelStep(cke, csn, cmd, bank, addr, dqm, dq);
        @(posedge sclk);
        #1;
        cyc++;
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) issue(1'b1, 1'b0, C_NOP, 2'd0, 11'd0, 4'd0, 32'd0);
    endtask

    task automatic act(input logic [1:0] bank, input logic [10:0] row);
        issue(1'b1, 1'b0, C_ACT, bank, row, 4'd0, 32'd0);
    endtask

    task automatic rd(input logic [1:0] bank, input logic [10:0] col, input logic [3:0] dqm);
        issue(1'b1, 1'b0, C_RD, bank, col, dqm, 32'd0);
    endtask

    task automatic wr(input logic [1:0] bank, input logic [10:0] col,
                      input logic [31:0] dq, input logic [3:0] dqm);
        issue(1'b1, 1'b0, C_WR, bank, col, dqm, dq);
    endtask

    // Reset is asserted between edges, held across two edges and released between edges.
    task automatic applyReset();
        iClkEn = 1'b0;
        iCsn   = 1'b1;
        {iRasn, iCasn, iWen} = C_NOP;
        sresetn = 1'b0;
        repeat (2) begin
            @(posedge sclk);
            #1;
            cyc++;
        end
        sresetn = 1'b1;
        modelReset();
    endtask

    task automatic test_reset();
        applyReset();
        checks++;
        if (oDq !== 32'h0) begin errors++; $display("[TB] FAIL reset_oDq actual=%h required=%h", oDq, 32'h0); end
        checks++;
        if (oDqOe !== 1'b0) begin errors++; $display("[TB] FAIL reset_oDqOe actual=%b required=0", oDqOe); end
        checks++;
        if (oErr !== 1'b0) begin errors++; $display("[TB] FAIL reset_oErr actual=%b required=0", oErr); end
        checks++;
        if (oErrCode !== 3'd0) begin errors++; $display("[TB] FAIL reset_oErrCode actual=%0d required=0", oErrCode); end
    endtask

    task automatic test_write_read_hit();
        act(2'd1, 11'h005);
        nop(1);
        wr(2'd1, 11'h012, 32'hDEADBEEF, 4'b0000);
        rd(2'd1, 11'h012, 4'b0000);
        nop(1);
        checks++;
        if (oDqOe !== 1'b0) begin errors++; $display("[TB] FAIL hit_early_oe actual=%b required=0", oDqOe); end
        nop(1);
        checks++;
        if (oDqOe !== 1'b1) begin errors++; $display("[TB] FAIL hit_oe actual=%b required=1", oDqOe); end
        checks++;
        if (oDq !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL hit_data actual=%h required=%h", oDq, 32'hDEADBEEF); end
        checks++;
        if (oErr !== 1'b0) begin errors++; $display("[TB] FAIL hit_err actual=%b required=0", oErr); end
    endtask

    task automatic test_byte_mask();
        nop(1);
        wr(2'd1, 11'h012, 32'h11223344, 4'b0101);
        rd(2'd1, 11'h012, 4'b0000);
        rd(2'd1, 11'h012, 4'b1000);
        nop(1);
        checks++;
        if ((oDqOe !== 1'b1) || (oDq !== 32'h11AD33EF)) begin
            errors++; $display("[TB] FAIL mask_wr actual=%b/%h required=1/%h", oDqOe, oDq, 32'h11AD33EF);
        end
        nop(1);
        checks++;
        if ((oDqOe !== 1'b1) || (oDq !== 32'h00AD33EF)) begin
            errors++; $display("[TB] FAIL mask_rd actual=%b/%h required=1/%h", oDqOe, oDq, 32'h00AD33EF);
        end
        nop(1);
        checks++;
        if ((oDqOe !== 1'b0) || (oDq !== 32'h0)) begin
            errors++; $display("[TB] FAIL mask_idle actual=%b/%h required=0/0", oDqOe, oDq);
        end
        checks++;
        if (oErr !== 1'b0) begin errors++; $display("[TB] FAIL mask_err actual=%b required=0", oErr); end
    endtask

    task automatic test_trcd();
        act(2'd2, 11'h000);
        rd(2'd2, 11'h003, 4'b0000);
        checks++;
        if ((oErr !== 1'b1) || (oErrCode !== 3'd3)) begin
            errors++; $display("[TB] FAIL trcd_code actual=%b/%0d required=1/3", oErr, oErrCode);
        end
        for (int i = 0; i < CL + 1; i++) begin
            nop(1);
            checks++;
            if (oDqOe !== 1'b0) begin errors++; $display("[TB] FAIL trcd_no_data actual=%b required=0", oDqOe); end
        end
        wr(2'd2, 11'h003, 32'hCAFEF00D, 4'b0000);
        rd(2'd2, 11'h003, 4'b0000);
        nop(2);
        checks++;
        if ((oDqOe !== 1'b1) || (oDq !== 32'hCAFEF00D)) begin
            errors++; $display("[TB] FAIL trcd_later_rd actual=%b/%h required=1/%h", oDqOe, oDq, 32'hCAFEF00D);
        end
        checks++;
        if (oErrCode !== 3'd3) begin errors++; $display("[TB] FAIL trcd_sticky actual=%0d required=3", oErrCode); end
    endtask

    task automatic test_precharge();
        applyReset();
        act(2'd0, 11'h002);
        act(2'd3, 11'h000);
        nop(2);
        issue(1'b1, 1'b0, C_PRE, 2'd0, 11'h400, 4'd0, 32'd0);
        act(2'd0, 11'h002);
        checks++;
        if ((oErr !== 1'b1) || (oErrCode !== 3'd4)) begin
            errors++; $display("[TB] FAIL trp_code actual=%b/%0d required=1/4", oErr, oErrCode);
        end

        applyReset();
        act(2'd0, 11'h002);
        act(2'd3, 11'h000);
        nop(2);
        issue(1'b1, 1'b0, C_PRE2, 2'd0, 11'h400, 4'd0, 32'd0);
        nop(2);
        act(2'd0, 11'h002);
        checks++;
        if (oErr !== 1'b0) begin errors++; $display("[TB] FAIL trp_b0_ok actual=%b required=0", oErr); end
        act(2'd3, 11'h000);
        checks++;
        if (oErr !== 1'b0) begin errors++; $display("[TB] FAIL pre_all_b3 actual=%b required=0", oErr); end
        nop(1);
        issue(1'b1, 1'b0, C_PRE, 2'd0, 11'h000, 4'd0, 32'd0);
        nop(2);
        act(2'd0, 11'h002);
        checks++;
        if (oErr !== 1'b0) begin errors++; $display("[TB] FAIL pre_one_b0 actual=%b required=0", oErr); end
        act(2'd3, 11'h000);
        checks++;
        if ((oErr !== 1'b1) || (oErrCode !== 3'd2)) begin
            errors++; $display("[TB] FAIL act_open_code actual=%b/%0d required=1/2", oErr, oErrCode);
        end
    endtask

    task automatic test_closed_bank_conflict();
        applyReset();
        rd(2'd1, 11'h000, 4'b0000);
        checks++;
        if ((oErr !== 1'b1) || (oErrCode !== 3'd1)) begin
            errors++; $display("[TB] FAIL closed_code actual=%b/%0d required=1/1", oErr, oErrCode);
        end
        nop(CL);
        checks++;
        if (oDqOe !== 1'b0) begin errors++; $display("[TB] FAIL closed_no_data actual=%b required=0", oDqOe); end

        applyReset();
        act(2'd0, 11'h000);
        nop(1);
        wr(2'd0, 11'h005, 32'hA5A50001, 4'b0000);
        rd(2'd0, 11'h005, 4'b0000);
        wr(2'd0, 11'h005, 32'h5A5AFFFF, 4'b0000);
        checks++;
        if ((oErr !== 1'b1) || (oErrCode !== 3'd5)) begin
            errors++; $display("[TB] FAIL conflict_code actual=%b/%0d required=1/5", oErr, oErrCode);
        end
        nop(1);
        checks++;
        if ((oDqOe !== 1'b1) || (oDq !== 32'hA5A50001)) begin
            errors++; $display("[TB] FAIL conflict_rd actual=%b/%h required=1/%h", oDqOe, oDq, 32'hA5A50001);
        end
        nop(1);
        rd(2'd0, 11'h005, 4'b0000);
        nop(2);
        checks++;
        if ((oDqOe !== 1'b1) || (oDq !== 32'hA5A50001)) begin
            errors++; $display("[TB] FAIL conflict_not_stored actual=%b/%h required=1/%h", oDqOe, oDq, 32'hA5A50001);
        end
    endtask

    task automatic test_reset_mid_read();
        applyReset();
        act(2'd0, 11'h000);
        nop(1);
        issue(1'b1, 1'b1, C_WR, 2'd0, 11'h005, 4'd0, 32'hBAD0BAD0);
        issue(1'b0, 1'b0, C_WR, 2'd0, 11'h005, 4'd0, 32'hBAD1BAD1);
        rd(2'd0, 11'h005, 4'b0000);
        nop(2);
        checks++;
        if ((oDqOe !== 1'b1) || (oDq !== 32'hA5A50001)) begin
            errors++; $display("[TB] FAIL deselect_wr actual=%b/%h required=1/%h", oDqOe, oDq, 32'hA5A50001);
        end
        rd(2'd0, 11'h005, 4'b0000);
        nop(1);
        applyReset();
        for (int i = 0; i < CL + 2; i++) begin
            nop(1);
            checks++;
            if ((oDqOe !== 1'b0) || (oDq !== 32'h0)) begin
                errors++; $display("[TB] FAIL reset_mid_read actual=%b/%h required=0/0", oDqOe, oDq);
            end
        end
    endtask

    task automatic test_random();
        bit          cke;
        bit          csn;
        bit          ap;
        logic [2:0]  cmd;
        logic [1:0]  bank;
        logic [10:0] addr;
        logic [3:0]  dqm;
        int          r;
        applyReset();
        for (int n = 0; n < 600; n++) begin
            if ((n % 150) == 149) applyReset();
            r    = int'($urandom_range(99));
            cke  = ($urandom_range(19) != 0);
            csn  = ($urandom_range(19) == 0);
            bank = 2'($urandom_range(3));
            ap   = ($urandom_range(4) == 0);
            dqm  = ($urandom_range(1) == 0) ? 4'b0000 : 4'($urandom_range(15));
            addr = {ap, 4'($urandom_range(15)), 6'($urandom_range(3))};
            if (r < 20)      cmd = C_NOP;
            else if (r < 40) begin cmd = C_ACT; addr = 11'($urandom_range(2047)); end
            else if (r < 62) cmd = C_RD;
            else if (r < 82) cmd = C_WR;
            else if (r < 92) cmd = ($urandom_range(1) == 0) ? C_PRE : C_PRE2;
            else             cmd = ($urandom_range(1) == 0) ? 3'b001 : 3'b110;
            issue(cke, csn, cmd, bank, addr, dqm, $urandom());
            checks++;
            if (oDqOe !== expOe) begin
                errors++; $display("[TB] FAIL rand_oe cycle=%0d actual=%b required=%b", cyc, oDqOe, expOe);
            end
            checks++;
            if (((oDq ^ expDq) & expCare) !== 32'h0) begin
                errors++; $display("[TB] FAIL rand_data cycle=%0d actual=%h required=%h care=%h", cyc, oDq, expDq, expCare);
            end
            checks++;
            if ((oErr !== expErr) || (oErrCode !== expCode)) begin
                errors++; $display("[TB] FAIL rand_err cycle=%0d actual=%b/%0d required=%b/%0d", cyc, oErr, oErrCode, expErr, expCode);
            end
        end
    endtask

    initial begin
        modelReset();
        test_reset();
        test_write_read_hit();
        test_byte_mask();
        test_trcd();
        test_precharge();
        test_closed_bank_conflict();
        test_reset_mid_read();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
